lut_cfg_bank: RTL and testbench

Bank of `CHANNELS` independent `WIDTH`-input lookup tables. The truth tables are reloaded at run time over a beat-serial configuration port, and the outputs are optionally registered. It generalises the fixed-function `$lut` gate mapping: one cell can act as any set of gates, and the function changes without re-synthesis. Truth-table indexing follows the `$lut` convention: `Y = LUT[A]`, with `A[0]` as the index LSB. The block is used as a soft reconfigurable-logic primitive in simulation models and as a generic FPGA-mappable building block.

---
 rtl/lut_cfg_pkg.sv | 27 ++
 rtl/lut_cfg_cell.sv | 14 +
 rtl/lut_cfg_bank.sv | 147 ++++++++++++++
 tb/tb_lut_cfg_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the reconfigurable LUT bank: FSM state
// encoding, table/beat sizing functions and the parameter-legality check.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } lut_state_e;

    // Bits in one channel's truth table.
    function automatic int lut_tsize(input int width);
        return 1 << width;
    endfunction

    // Configuration beats needed to fill the whole bank.
    function automatic int lut_beats(input int width, input int channels, input int cfg_bits);
        return (channels * lut_tsize(width)) / cfg_bits;
    endfunction

    // The flat table must split into a whole number of configuration beats.
    function automatic bit lut_params_ok(input int width, input int channels, input int cfg_bits);
        return (width >= 1) && (channels >= 1) && (cfg_bits >= 1) &&
               (((channels * lut_tsize(width)) % cfg_bits) == 0);
    endfunction

endpackage

// File: rtl/lut_cfg_cell.sv
// Single-channel truth-table lookup: y = table[idx], idx[0] is the index LSB.
module lut_cfg_cell
    import lut_cfg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [lut_tsize(WIDTH)-1:0] table_i,
    input  logic [WIDTH-1:0]            idx_i,
    output logic                        y_o
);

    assign y_o = table_i[idx_i];

endmodule

// File: rtl/lut_cfg_bank.sv
// Bank of CHANNELS independent WIDTH-input LUTs. A new bank-wide table is
// streamed LSB-first into a shadow register and swapped into the active
// table in a single cycle, so lookups never observe a partially loaded table.
module lut_cfg_bank
    import lut_cfg_pkg::*;
#(
    parameter int                              WIDTH    = 4,
    parameter int                              CHANNELS = 4,
    parameter int                              CFG_BITS = 8,
    parameter logic [CHANNELS*(2**WIDTH)-1:0]  INIT     = '0,
    parameter bit                              REG_OUT  = 1'b1
) (
    input  logic                        CLK,
    input  logic                        SRST,
    input  logic                        CFG_START,
    input  logic                        CFG_VALID,
    output logic                        CFG_READY,
    input  logic [CFG_BITS-1:0]         CFG_DATA,
    output logic                        CFG_DONE,
    input  logic [CHANNELS*WIDTH-1:0]   A,
    input  logic                        EN,
    output logic [CHANNELS-1:0]         Y,
    output logic                        Y_VALID
);

    localparam int T     = lut_tsize(WIDTH);
    localparam int TBL   = CHANNELS * T;
    localparam int BEATS = lut_beats(WIDTH, CHANNELS, CFG_BITS);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (!lut_params_ok(WIDTH, CHANNELS, CFG_BITS)) begin : g_bad_params
        $error("lut_cfg_bank: CHANNELS*2**WIDTH must be a multiple of CFG_BITS");
    end

    lut_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TBL-1:0]       shadow_q, shadow_d;
    logic [TBL-1:0]       active_q, active_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic [CHANNELS-1:0]  y_lut;

    // Configuration FSM: next state, beat counter, shadow fill and table swap.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (CFG_START) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                // A restart wins over a beat offered in the same cycle.
                if (CFG_START) begin
                    cnt_d = '0;
                end else if (CFG_VALID && ready_q) begin
                    shadow_d[int'(cnt_q)*CFG_BITS +: CFG_BITS] = CFG_DATA;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                active_d = shadow_q;
                done_d   = 1'b1;
                state_d  = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        ready_d = (state_d == ST_LOAD);
    end

    // Control state and the active table, synchronously reset to RUN / INIT.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (SRST) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            active_q <= INIT;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // Shadow table storage; fully rewritten by every load before it is used.
    always_ff @(posedge CLK) begin
        // NOTE: no reset on this wide data register; its contents are never observed until reloaded.
        shadow_q <= shadow_d;
    end

    assign CFG_READY = ready_q;
    assign CFG_DONE  = done_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
        lut_cfg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .table_i (active_q[c*T +: T]),
            .idx_i   (A[c*WIDTH +: WIDTH]),
            .y_o     (y_lut[c])
        );
    end

    if (REG_OUT) begin : g_reg_out
        logic [CHANNELS-1:0] y_q, y_d;
        logic                y_valid_q, y_valid_d;

        // Capture a fresh lookup when enabled, otherwise hold the last result.
        always_comb begin
            y_d       = EN ? y_lut : y_q;
            y_valid_d = EN;
        end

        // Output register, cleared by reset.
        always_ff @(posedge CLK) begin
            if (SRST) begin
                y_q       <= '0;
                y_valid_q <= 1'b0;
            end else begin
                y_q       <= y_d;
                y_valid_q <= y_valid_d;
            end
        end

        assign Y       = y_q;
        assign Y_VALID = y_valid_q;
    end else begin : g_comb_out
        assign Y       = y_lut;
        assign Y_VALID = EN;
    end

endmodule

// File: tb/tb_lut_cfg_bank.sv
// Randomised self-checking bench for lut_cfg_bank. A protocol-level model
// (beat queue + flat table) predicts the registered DUT every cycle; a second
// instance with combinational outputs and a fixed INIT table is checked too.
module tb_lut_cfg_bank;

    localparam int W     = 2;
    localparam int C     = 2;
    localparam int CB    = 4;
    localparam int T     = 4;
    localparam int BEATS = 2;
    localparam logic [7:0] INIT_A = 8'h00;
    localparam logic [7:0] INIT_B = 8'h6E;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_data = 4'h0;
    logic [3:0] a = 4'h0;
    logic       en = 1'b0;

    logic       cfg_ready, cfg_done, y_valid;
    logic [1:0] y;
    logic       cfg_ready2, cfg_done2, y_valid2;
    logic [1:0] y2;

    int n_checks = 0;
    int n_fail   = 0;

    bit rand_ae  = 1'b0;
    bit en_force = 1'b0;

    always #5 clk = ~clk;

    lut_cfg_bank #(
        .WIDTH(W), .CHANNELS(C), .CFG_BITS(CB), .INIT(INIT_A), .REG_OUT(1'b1)
    ) dut (
        .CLK(clk), .SRST(srst), .CFG_START(cfg_start), .CFG_VALID(cfg_valid),
        .CFG_READY(cfg_ready), .CFG_DATA(cfg_data), .CFG_DONE(cfg_done),
        .A(a), .EN(en), .Y(y), .Y_VALID(y_valid)
    );

    lut_cfg_bank #(
        .WIDTH(W), .CHANNELS(C), .CFG_BITS(CB), .INIT(INIT_B), .REG_OUT(1'b0)
    ) dut_comb (
        .CLK(clk), .SRST(srst), .CFG_START(1'b0), .CFG_VALID(1'b0),
        .CFG_READY(cfg_ready2), .CFG_DATA(4'h0), .CFG_DONE(cfg_done2),
        .A(a), .EN(en), .Y(y2), .Y_VALID(y_valid2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Y[c] = table[c*T + index of channel c]
    function automatic logic [1:0] lookup(input logic [7:0] tbl, input logic [3:0] idx);
        logic [1:0] r;
        r = '0;
        for (int c = 0; c < C; c++) begin
            int ai;
            ai = (int'(idx) >> (c * W)) % T;
            r[c] = tbl[c*T + ai];
        end
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    bit         m_ok = 1'b0;
    bit         m_loading, m_pending, m_done, m_ready, m_valid;
    logic [7:0] m_active, m_new, m_old;
    logic [1:0] m_y;
    logic [3:0] beat_q[$];

    always @(posedge clk) begin
        if (srst) begin
            m_ok      = 1'b1;
            m_loading = 1'b0;
            m_pending = 1'b0;
            m_done    = 1'b0;
            m_ready   = 1'b0;
            m_valid   = 1'b0;
            m_y       = 2'b00;
            m_active  = INIT_A;
            beat_q.delete();
        end else if (m_ok) begin
            m_old  = m_active;
            m_done = m_pending;
            if (en) m_y = lookup(m_old, a);
            m_valid = en;
            if (m_pending) begin
                m_active  = m_new;
                m_pending = 1'b0;
            end else if (!m_loading) begin
                if (cfg_start) begin
                    m_loading = 1'b1;
                    beat_q.delete();
                end
            end else if (cfg_start) begin
                beat_q.delete();
            end else if (cfg_valid) begin
                beat_q.push_back(cfg_data);
                if (beat_q.size() == BEATS) begin
                    for (int k = 0; k < BEATS; k++) m_new[k*CB +: CB] = beat_q[k];
                    m_pending = 1'b1;
                    m_loading = 1'b0;
                end
            end
            m_ready = m_loading;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            check("y", y, m_y);
            check("y_valid", y_valid, m_valid);
            check("cfg_ready", cfg_ready, m_ready);
            check("cfg_done", cfg_done, m_done);
            check("comb_y", y2, lookup(INIT_B, a));
            check("comb_y_valid", y_valid2, en);
            check("comb_cfg_ready", cfg_ready2, 1'b0);
            check("comb_cfg_done", cfg_done2, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ae) begin
            a  = 4'($urandom);
            en = en_force ? 1'b1 : 1'($urandom);
        end
    endtask

    task automatic send_beat(input logic [3:0] d, input int stall_lo, input int stall_hi);
        repeat ($urandom_range(stall_hi, stall_lo)) begin
            cfg_data = 4'($urandom);
            tick();
        end
        cfg_valid = 1'b1;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Full reload; the cycle after the last beat is the commit cycle.
    task automatic load(input logic [3:0] b0, input logic [3:0] b1,
                        input int stall_lo, input int stall_hi, input bit poke_commit);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_beat(b0, stall_lo, stall_hi);
        send_beat(b1, stall_lo, stall_hi);
        cfg_start = poke_commit;
        tick();
        cfg_start = 1'b0;
        check("done_pulse", cfg_done, 1'b1);
    endtask

    task automatic lit(input string name, input logic [3:0] idx, input logic [1:0] exp);
        rand_ae = 1'b0;
        en = 1'b1;
        a  = idx;
        tick();
        check(name, y, exp);
        check({name, "_valid"}, y_valid, 1'b1);
    endtask

    initial begin
        // 1: reset
        srst = 1'b1;
        repeat (2) tick();
        srst = 1'b0;
        lit("s1_reset_y", 4'b1111, 2'b00);
        check("s1_done", cfg_done, 1'b0);
        check("s1_ready", cfg_ready, 1'b0);

        // 2: load AND (ch0) / XOR (ch1)
        load(4'b1000, 4'b0110, 0, 0, 1'b0);
        lit("s2_0111", 4'b0111, 2'b11);
        lit("s2_1111", 4'b1111, 2'b01);
        lit("s2_1000", 4'b1000, 2'b10);

        // 3: stalled load (NAND / OR) with evaluation running throughout
        rand_ae = 1'b1;
        en_force = 1'b1;
        load(4'h7, 4'hE, 5, 5, 1'b0);
        en_force = 1'b0;
        lit("s3_0000", 4'b0000, 2'b01);
        lit("s3_0111", 4'b0111, 2'b10);

        // 4: restart; a beat coinciding with CFG_START is dropped
        rand_ae = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_beat(4'hF, 0, 0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 4'hF;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        send_beat(4'h8, 0, 2);
        send_beat(4'h6, 0, 2);
        tick();
        check("s4_done", cfg_done, 1'b1);
        lit("s4_0111", 4'b0111, 2'b11);
        lit("s4_1111", 4'b1111, 2'b01);

        // 5: reset in the middle of a load
        rand_ae = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_beat(4'h9, 0, 0);
        srst = 1'b1;
        repeat (2) tick();
        srst = 1'b0;
        check("s5_ready", cfg_ready, 1'b0);
        check("s5_done", cfg_done, 1'b0);
        lit("s5_init", 4'b1111, 2'b00);
        load(4'b1000, 4'b0110, 0, 1, 1'b0);
        lit("s5_reload", 4'b0111, 2'b11);

        // 6: combinational instance, same-cycle lookup of INIT 8'h6E
        rand_ae = 1'b0;
        en = 1'b1;
        a  = 4'b0100;
        #1;
        check("s6_y", y2, 2'b10);
        check("s6_y_valid", y_valid2, 1'b1);

        // Random reloads with random stalls, idles and CFG_START during COMMIT
        rand_ae = 1'b1;
        for (int i = 0; i < 25; i++) begin
            load(4'($urandom), 4'($urandom), 0, 3, 1'($urandom));
            repeat ($urandom_range(6, 1)) tick();
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
